// File: rtl/sobel_window_ctrl.sv
// Sobel 3x3 window controller.
// Paces upstream pixels into the line buffers and window registers. It tracks
// the column and row of each accepted pixel and flags when the 3x3 window at the
// buffer outputs is complete. One frame runs per Start request.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       PixValid,
    input  logic       OutReady,
    output logic       PixReady,
    output logic       LineEnable,
    output logic       WinValid,
    output logic [9:0] WinCol,
    output logic [8:0] WinRow,
    output logic       Busy,
    output logic       Done
);

    localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [8:0] ROW_LAST = 9'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] col_q, col_d;
    logic [8:0] row_q, row_d;
    logic       win_valid_q, win_valid_d;
    logic [9:0] win_col_q, win_col_d;
    logic [8:0] win_row_q, win_row_d;
    logic       done_q, done_d;

    logic       pix_ready;
    logic       accept;

    // Handshake is gated by reset in the same cycle so nothing shifts while RST is high.
    assign pix_ready  = !RST && (state_q == ST_STREAM) && OutReady;
    assign accept     = pix_ready && PixValid;

    assign PixReady   = pix_ready;
    assign LineEnable = accept;
    assign Busy       = (state_q == ST_STREAM);
    assign WinValid   = win_valid_q;
    assign WinCol     = win_col_q;
    assign WinRow     = win_row_q;
    assign Done       = done_q;

    // Next-state logic: frame sequencing, raster counters and window tagging.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = 1'b0;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    // A window is complete only once two earlier rows and two
                    // earlier columns exist, so none straddles a line wrap.
                    win_valid_d = (row_q >= 9'd2) && (col_q >= 10'd2);
                    win_col_d   = col_q;
                    win_row_d   = row_q;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + 9'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, with reset taking priority over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line (legal range 3..1023).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (legal range 3..511).
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous reset, active-high.
REQ-005 SHALL have port Start  input  1  frame start request, sampled in IDLE only.
REQ-006 SHALL have port PixValid  input  1  upstream pixel available.
REQ-007 SHALL have port OutReady  input  1  downstream able to accept a window.
REQ-008 SHALL have port PixReady  output  1  controller accepts pixel this cycle (combinational).
REQ-009 SHALL have port LineEnable  output  1  shift enable to the line-buffer FIFOs and window registers (combinational).
REQ-010 SHALL have port WinValid  output  1  3x3 window at the line-buffer outputs is complete (registered).
REQ-011 SHALL have port WinCol  output  10  column of the window centre pixel + 1, i.e. column of newest pixel (registered).
REQ-012 SHALL have port WinRow  output  9  row of newest pixel (registered).
REQ-013 SHALL have port Busy  output  1  high in STREAM state.
REQ-014 SHALL have port Done  output  1  one-cycle pulse at frame end (registered).

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-016 SHALL transition IDLE->STREAM on the edge where Start=1; Start in STREAM or DONE SHALL be ignored.
REQ-017 SHALL drive PixReady = (state==STREAM) && OutReady; PixReady SHALL be 0 in IDLE and DONE.
REQ-018 SHALL define accept = PixValid && PixReady and drive LineEnable = accept; no shift otherwise.
REQ-019 SHALL hold col counter (10 bit) and row counter (9 bit), both 0 on entering STREAM.
REQ-020 On accept, col SHALL increment; at col==IMG_WIDTH-1 col SHALL wrap to 0 and row SHALL increment.
REQ-021 On accept at col==IMG_WIDTH-1 and row==IMG_HEIGHT-1, FSM SHALL go STREAM->DONE and both counters SHALL clear to 0.
REQ-022 DONE SHALL last exactly one cycle with Done=1, then return to IDLE; Start in DONE SHALL not be honoured.
REQ-023 WinValid SHALL be 1 in the cycle after an accept whose pre-increment row>=2 and col>=2, else 0.
REQ-024 WinCol/WinRow SHALL capture the pre-increment col/row on every accept and hold otherwise.
REQ-025 Windows per frame SHALL equal (IMG_WIDTH-2)*(IMG_HEIGHT-2); no window SHALL straddle a line wrap.
REQ-026 PixValid with OutReady=0 SHALL stall: no accept, counters and WinCol/WinRow hold, WinValid=0 next cycle.
REQ-027 PixValid=1 while IDLE or DONE SHALL be ignored (no shift, counters unchanged).
REQ-028 Counter arithmetic SHALL be unsigned; no counter SHALL exceed IMG_WIDTH-1 / IMG_HEIGHT-1.

Reset
REQ-029 On RST=1 at a clock edge, state SHALL become IDLE, col=0, row=0, WinValid=0, WinCol=0, WinRow=0, Done=0.
REQ-030 RST SHALL take priority over Start, accept and all transitions, including mid-frame in STREAM.
REQ-031 While RST=1, PixReady and LineEnable SHALL be 0 (state forced IDLE from next edge; combinational outputs gated by RST in the same cycle).

Verification (IMG_WIDTH=4, IMG_HEIGHT=3 unless stated)
REQ-032 Start pulse, PixValid=1, OutReady=1 for 12 cycles -> 12 LineEnable pulses, WinValid exactly 2 cycles with (WinRow,WinCol)=(2,2),(2,3), Done=1 one cycle after 12th accept, then IDLE.
REQ-033 Same stream with OutReady=0 for 3 cycles after pixel 6 -> PixReady=0 and LineEnable=0 for those 3 cycles, counters frozen at row=1,col=2, frame completes with total 12 accepts and 2 windows.
REQ-034 PixValid=1 and Start=0 in IDLE for 10 cycles -> LineEnable never 1, Busy=0, counters stay 0.
REQ-035 RST=1 after 7 accepts -> next cycle state IDLE, col=0, row=0, WinValid=0; new Start restarts frame at (0,0).
REQ-036 Start=1 held continuously through frame -> exactly one frame per IDLE visit; Done pulse, one idle cycle, then next frame begins.
REQ-037 IMG_WIDTH=3, IMG_HEIGHT=3, continuous stream -> exactly 1 WinValid at (2,2), coincident with Done on the following cycle.
